alu_share_arbiter: RTL and testbench

Shares one ArithmeticLogicUnit instance between two requesters, for example the main datapath and a debug/microcode engine. The block arbitrates round-robin and steers the winner's operands onto the ALU input ports. It captures ALUOut/Zero into a single result register and returns the result to the winning requester over a valid/ready response channel. The ALU itself is external; this block drives its inputs and samples its outputs.

---
 rtl/alu_share_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : alu_share_arbiter                                           |
// | Purpose  : round-robin share of one external ALU between two          |
// |            requesters with a registered valid/ready result slot.       |
// |            Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req 0).    |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module alu_share_arbiter #(
  parameter int AWL  = 6,
  parameter int DWL  = 32,
  parameter int CNTW = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [1:0]       ReqValid,
  output logic [1:0]       ReqReady,
  input  logic [DWL-1:0]   ReqIn1_0,
  input  logic [DWL-1:0]   ReqIn2_0,
  input  logic [DWL-1:0]   ReqIn1_1,
  input  logic [DWL-1:0]   ReqIn2_1,
  input  logic [AWL-2:0]   ReqShamt_0,
  input  logic [AWL-2:0]   ReqShamt_1,
  input  logic [AWL-3:0]   ReqSel_0,
  input  logic [AWL-3:0]   ReqSel_1,
  output logic [DWL-1:0]   ALUIn1,
  output logic [DWL-1:0]   ALUIn2,
  output logic [AWL-2:0]   ALUShamt,
  output logic [AWL-3:0]   ALUSel,
  input  logic [DWL-1:0]   ALUOut,
  input  logic             ALUZero,
  output logic [1:0]       RspValid,
  input  logic [1:0]       RspReady,
  output logic [DWL-1:0]   RspData,
  output logic             RspZero,
  output logic             RspErr,
  output logic [CNTW-1:0]  IssueCnt0,
  output logic [CNTW-1:0]  IssueCnt1
);

  localparam logic [AWL-3:0] c_sel_bad_a = (AWL-2)'(4'b1101);
  localparam logic [AWL-3:0] c_sel_bad_b = (AWL-2)'(4'b1110);

  logic [1:0]      r_rsp_valid;
  logic [DWL-1:0]  r_rsp_data;
  logic            r_rsp_zero;
  logic            r_rsp_err;
  logic            r_last_grant;
  logic [CNTW-1:0] r_cnt0;
  logic [CNTW-1:0] r_cnt1;

  logic [1:0]      w_grant;
  logic            w_slot_free;
  logic [1:0]      w_accept;
  logic            w_sel_bad;

  // Grant is forced off while reset is asserted so nothing is offered to requesters.
  always_comb begin
    w_grant = 2'b00;
    if (RST_N) begin
      case (ReqValid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11: begin
`ifdef ALU_ARB_FIXED_PRIO_EN
          w_grant = 2'b01;
`else
          w_grant = r_last_grant ? 2'b01 : 2'b10;
`endif
        end
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign w_slot_free = (r_rsp_valid == 2'b00) | (|(r_rsp_valid & RspReady));
  assign ReqReady    = w_grant & {2{w_slot_free}};
  assign w_accept    = ReqValid & ReqReady;

  always_comb begin
    ALUIn1   = '0;
    ALUIn2   = '0;
    ALUShamt = '0;
    ALUSel   = '0;
    if (w_grant[0]) begin
      ALUIn1   = ReqIn1_0;
      ALUIn2   = ReqIn2_0;
      ALUShamt = ReqShamt_0;
      ALUSel   = ReqSel_0;
    end else if (w_grant[1]) begin
      ALUIn1   = ReqIn1_1;
      ALUIn2   = ReqIn2_1;
      ALUShamt = ReqShamt_1;
      ALUSel   = ReqSel_1;
    end
  end

  assign w_sel_bad = (ALUSel == c_sel_bad_a) | (ALUSel == c_sel_bad_b);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_rsp_valid  <= 2'b00;
      r_rsp_data   <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
    end else if (|w_accept) begin
      r_rsp_valid  <= w_accept;
      r_rsp_data   <= w_sel_bad ? '0 : ALUOut;
      r_rsp_zero   <= w_sel_bad ? 1'b1 : ALUZero;
      r_rsp_err    <= w_sel_bad;
      r_last_grant <= w_accept[1];
      if (w_accept[0]) r_cnt0 <= r_cnt0 + CNTW'(1);
      if (w_accept[1]) r_cnt1 <= r_cnt1 + CNTW'(1);
    end else if (|(r_rsp_valid & RspReady)) begin
      // Consumed with no replacement: data registers keep their last value.
      r_rsp_valid <= 2'b00;
    end
  end

  assign RspValid  = r_rsp_valid;
  assign RspData   = r_rsp_data;
  assign RspZero   = r_rsp_zero;
  assign RspErr    = r_rsp_err;
  assign IssueCnt0 = r_cnt0;
  assign IssueCnt1 = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_alu_share_arbiter                                        |
// | Purpose  : directed self-checking bench with a small behavioural ALU.  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_alu_share_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [1:0]  ReqValid, ReqReady, RspValid, RspReady;
  logic [31:0] ReqIn1_0, ReqIn2_0, ReqIn1_1, ReqIn2_1;
  logic [4:0]  ReqShamt_0, ReqShamt_1, ALUShamt;
  logic [3:0]  ReqSel_0, ReqSel_1, ALUSel;
  logic [31:0] ALUIn1, ALUIn2, ALUOut, RspData;
  logic        ALUZero, RspZero, RspErr;
  logic [15:0] IssueCnt0, IssueCnt1;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // Behavioural ALU standing in for the external unit.
  always_comb begin
    ALUOut = 32'd0;
    case (ALUSel)
      4'b0000: ALUOut = ALUIn1 + ALUIn2;
      4'b0001: ALUOut = ALUIn1 - ALUIn2;
      4'b0010: ALUOut = ALUIn1 & ALUIn2;
      4'b0011: ALUOut = ALUIn1 | ALUIn2;
      4'b0100: ALUOut = ALUIn1 ^ ALUIn2;
      4'b0101: ALUOut = ALUIn1 << ALUShamt;
      default: ALUOut = 32'hDEAD_BEEF;
    endcase
  end
  assign ALUZero = (ALUOut == 32'd0);

  alu_share_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqIn1_0(ReqIn1_0), .ReqIn2_0(ReqIn2_0),
    .ReqIn1_1(ReqIn1_1), .ReqIn2_1(ReqIn2_1),
    .ReqShamt_0(ReqShamt_0), .ReqShamt_1(ReqShamt_1),
    .ReqSel_0(ReqSel_0), .ReqSel_1(ReqSel_1),
    .ALUIn1(ALUIn1), .ALUIn2(ALUIn2), .ALUShamt(ALUShamt), .ALUSel(ALUSel),
    .ALUOut(ALUOut), .ALUZero(ALUZero),
    .RspValid(RspValid), .RspReady(RspReady),
    .RspData(RspData), .RspZero(RspZero), .RspErr(RspErr),
    .IssueCnt0(IssueCnt0), .IssueCnt1(IssueCnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; ReqValid = 2'b11; RspReady = 2'b11;
    ReqIn1_0 = 32'd1;    ReqIn2_0 = 32'd1;    ReqSel_0 = 4'b0000; ReqShamt_0 = 5'd0;
    ReqIn1_1 = 32'hF0;   ReqIn2_1 = 32'h0F;   ReqSel_1 = 4'b0010; ReqShamt_1 = 5'd0;

    // Reset with both requesting
    step();
    check("rst_reqready", 32'(ReqReady), 32'd0);
    check("rst_alusel", 32'(ALUSel), 32'd0);
    step();
    check("rst_rspvalid", 32'(RspValid), 32'd0);
    check("rst_cnt0", 32'(IssueCnt0), 32'd0);
    check("rst_cnt1", 32'(IssueCnt1), 32'd0);
    check("rst_rspdata", RspData, 32'd0);
    check("rst_rsperr", 32'(RspErr), 32'd0);
    RST_N = 1'b1;

    // Contention: grants 0,1,0,1 with results 2,0
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cont_reqready", 32'(ReqReady), (k % 2 == 0) ? 32'd1 : 32'd2);
      step();
      check("cont_rspvalid", 32'(RspValid), (k % 2 == 0) ? 32'd1 : 32'd2);
      check("cont_rspdata", RspData, (k % 2 == 0) ? 32'd2 : 32'd0);
      check("cont_rspzero", 32'(RspZero), (k % 2 == 0) ? 32'd0 : 32'd1);
    end
    check("cont_cnt0", 32'(IssueCnt0), 32'd2);
    check("cont_cnt1", 32'(IssueCnt1), 32'd2);

    // Single requester 0: 7 - 5
    ReqValid = 2'b01; ReqIn1_0 = 32'd7; ReqIn2_0 = 32'd5; ReqSel_0 = 4'b0001;
    #1;
    check("single_reqready", 32'(ReqReady), 32'd1);
    check("single_aluin1", ALUIn1, 32'd7);
    step();
    check("single_rspvalid", 32'(RspValid), 32'd1);
    check("single_rspdata", RspData, 32'd2);
    check("single_rspzero", 32'(RspZero), 32'd0);
    check("single_cnt0", 32'(IssueCnt0), 32'd3);

    // Backpressure: hold result, both requesting
    RspReady = 2'b00; ReqValid = 2'b11;
    ReqIn1_0 = 32'd1; ReqIn2_0 = 32'd1; ReqSel_0 = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_reqready", 32'(ReqReady), 32'd0);
      step();
      check("bp_rspvalid", 32'(RspValid), 32'd1);
      check("bp_rspdata", RspData, 32'd2);
    end
    RspReady = 2'b10;
    #1;
    check("bp_nonowner_reqready", 32'(ReqReady), 32'd0);
    step();
    check("bp_nonowner_rspvalid", 32'(RspValid), 32'd1);
    RspReady = 2'b01;
    #1;
    check("bp_release_reqready", 32'(ReqReady), 32'd2);
    step();
    check("bp_release_rspvalid", 32'(RspValid), 32'd2);
    check("bp_release_rspdata", RspData, 32'd0);
    check("bp_release_rspzero", 32'(RspZero), 32'd1);
    check("bp_release_cnt1", 32'(IssueCnt1), 32'd3);

    // Unsupported op on requester 1
    RspReady = 2'b11; ReqValid = 2'b10; ReqSel_1 = 4'b1101;
    #1;
    check("ill_reqready", 32'(ReqReady), 32'd2);
    step();
    check("ill_rspvalid", 32'(RspValid), 32'd2);
    check("ill_rsperr", 32'(RspErr), 32'd1);
    check("ill_rspdata", RspData, 32'd0);
    check("ill_rspzero", 32'(RspZero), 32'd1);
    check("ill_cnt1", 32'(IssueCnt1), 32'd4);
    ReqSel_1 = 4'b1110;
    step();
    check("ill2_rsperr", 32'(RspErr), 32'd1);
    check("ill2_cnt1", 32'(IssueCnt1), 32'd5);
    ReqValid = 2'b00;
    step();
    check("drain_rspvalid", 32'(RspValid), 32'd0);
    check("drain_rspdata_hold", RspData, 32'd0);

    // Good op clears the error flag
    ReqValid = 2'b01; ReqIn1_0 = 32'd3; ReqIn2_0 = 32'd4; ReqSel_0 = 4'b0011;
    step();
    check("ok_rsperr", 32'(RspErr), 32'd0);
    check("ok_rspdata", RspData, 32'd7);
    check("ok_cnt0", 32'(IssueCnt0), 32'd4);

    // Counter wrap: 4 -> 65535 -> 0
    repeat (65531) step();
    check("wrap_cnt0_max", 32'(IssueCnt0), 32'd65535);
    step();
    check("wrap_cnt0_zero", 32'(IssueCnt0), 32'd0);
    check("wrap_rspvalid", 32'(RspValid), 32'd1);

    // Mid-transaction reset discards the held result
    RST_N = 1'b0; ReqValid = 2'b00;
    step();
    check("midrst_rspvalid", 32'(RspValid), 32'd0);
    check("midrst_cnt1", 32'(IssueCnt1), 32'd0);
    RST_N = 1'b1; ReqValid = 2'b11;
    #1;
    check("midrst_lastgrant", 32'(ReqReady), 32'd1);
    step();
    check("midrst_first_rspvalid", 32'(RspValid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
